// File: rtl/arm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arm_pkg
//  Description : Shared types and constants for the 5-stage ARM pipeline
//                control slice (IF/ID/EXE/MEM/WB).
//                - seq_state_t : pipeline sequencer FSM states
//                - REG_W_DEF   : default register-address width (R0..R15)
//                - NOP_CTRL    : control word loaded into ID/EXE for a bubble
//  Revision    : 1.0 - initial release
// ============================================================================
package arm_pkg;

    localparam int REG_W_DEF = 4;

    // RUN      : pipeline flowing, or a zero-wait SRAM access in progress
    // MEM_WAIT : MEM stage is waiting on a multi-cycle SRAM access
    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } seq_state_t;

    // Execute-stage control bundle carried by the ID/EXE register.
    typedef struct packed {
        logic       wb_en;
        logic       mem_rd;
        logic       mem_wr;
        logic [3:0] exe_cmd;
        logic       branch;
        logic       set_flags;
    } id_exe_ctrl_t;

    // A bubble is an instruction with every side effect disabled.
    localparam id_exe_ctrl_t NOP_CTRL = '{
        wb_en     : 1'b0,
        mem_rd    : 1'b0,
        mem_wr    : 1'b0,
        exe_cmd   : 4'h0,
        branch    : 1'b0,
        set_flags : 1'b0
    };

endpackage : arm_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Saturating up-counter used for pipeline performance events.
//                Counts one per cycle with inc=1 and sticks at all-ones.
//  Ports       : clk    in   clock
//                rst_n  in   asynchronous reset, active-low
//                inc    in   count this cycle
//                count  out  CNT_W current value
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = (r_count == {CNT_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && !w_at_max) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipeline_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_sequencer
//  Description : Central stall/flush sequencer for the 5-stage ARM pipeline.
//                RAW hazard detection ID vs EXE/MEM, taken-branch flush,
//                whole-pipeline hold during multi-cycle SRAM accesses with a
//                timeout watchdog, and saturating stall/flush counters.
//                All control outputs are combinational from inputs and state.
//  Ports       : clk, rst_n                     clock, async active-low reset
//                fwd_en                         forwarding unit active
//                id_src1/id_src2/id_two_src     ID-stage source operands
//                exe_dest/exe_wb_en/exe_mem_rd  EXE-stage destination info
//                mem_dest/mem_wb_en             MEM-stage destination info
//                mem_rd_en/mem_wr_en/mem_ready  MEM-stage SRAM handshake
//                branch_taken                   EXE resolved a taken branch
//                freeze_if_id/bubble_exe        front-end stall controls
//                flush_if_id/flush_id_exe       wrong-path flush controls
//                freeze_back                    back-end hold
//                mem_req                        SRAM request (level)
//                mem_timeout                    sticky access-abort flag
//                stall_count/flush_count        saturating event counters
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_sequencer
    import arm_pkg::*;
#(
    parameter int REG_W       = REG_W_DEF,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fwd_en,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_rd,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    input  logic             mem_rd_en,
    input  logic             mem_wr_en,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             freeze_if_id,
    output logic             bubble_exe,
    output logic             flush_if_id,
    output logic             flush_id_exe,
    output logic             freeze_back,
    output logic             mem_req,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    // wait counter only ever holds 0..TIMEOUT_CYC-1
    localparam int                WAIT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_cnt_nxt;
    logic              r_timeout;

    logic w_mem_acc;
    logic w_mem_req;
    logic w_mem_hold;
    logic w_abort;
    logic w_flush;
    logic w_haz;
    logic w_hit1;
    logic w_hit2;
    logic w_freeze;

    assign w_mem_acc = mem_rd_en | mem_wr_en;

    // ------------------------------------------------------------------
    // SRAM wait FSM. r_wait_cnt is the number of access cycles already
    // spent, so the RUN cycle that starts a stalled access counts as the
    // first one and the abort lands on access cycle TIMEOUT_CYC.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_mem_req      = 1'b0;
        w_mem_hold     = 1'b0;
        w_abort        = 1'b0;
        case (r_state)
            RUN: begin
                w_wait_cnt_nxt = '0;
                if (w_mem_acc) begin
                    w_mem_req = 1'b1;
                    if (!mem_ready) begin
                        w_mem_hold     = 1'b1;
                        w_state_nxt    = MEM_WAIT;
                        w_wait_cnt_nxt = WAIT_W'(1);
                    end
                end
            end
            MEM_WAIT: begin
                w_mem_req = 1'b1;
                if (mem_ready) begin
                    w_state_nxt    = RUN;
                    w_wait_cnt_nxt = '0;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    // Give up: release the pipeline and let the instruction
                    // retire with undefined load data.
                    w_mem_req      = 1'b0;
                    w_abort        = 1'b1;
                    w_state_nxt    = RUN;
                    w_wait_cnt_nxt = '0;
                end else begin
                    w_mem_hold     = 1'b1;
                    w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
                end
            end
            default: begin
                w_state_nxt    = RUN;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_abort) begin
                r_timeout <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Flush and hazard. Priority is mem_hold > flush > haz: a branch held
    // in EXE behind a memory wait flushes only on the advancing cycle, and
    // a hazard is moot when the front end is being flushed or frozen.
    // ------------------------------------------------------------------
    assign w_flush = branch_taken & ~w_mem_hold;

    // An EXE producer forces a stall only if its value cannot be forwarded
    // (load result not yet available, or forwarding disabled); a MEM
    // producer is always forwardable when forwarding is on.
    assign w_hit1 = ((id_src1 == exe_dest) & exe_wb_en & (exe_mem_rd | ~fwd_en))
                  | ((id_src1 == mem_dest) & mem_wb_en & ~fwd_en);
    assign w_hit2 = ((id_src2 == exe_dest) & exe_wb_en & (exe_mem_rd | ~fwd_en))
                  | ((id_src2 == mem_dest) & mem_wb_en & ~fwd_en);

    assign w_haz    = (w_hit1 | (id_two_src & w_hit2)) & ~w_flush & ~w_mem_hold;
    assign w_freeze = w_haz | w_mem_hold;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_freeze),
        .count (stall_count)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_flush),
        .count (flush_count)
    );

    assign freeze_if_id = w_freeze;
    assign bubble_exe   = w_haz;
    assign flush_if_id  = w_flush;
    assign flush_id_exe = w_flush;
    assign freeze_back  = w_mem_hold;
    assign mem_req      = w_mem_req;
    assign mem_timeout  = r_timeout;

endmodule : pipeline_sequencer
`default_nettype wire

// File: tb/tb_pipeline_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_sequencer
//  Description : Scoreboard bench for pipeline_sequencer. The driver applies
//                one directed vector per cycle just after posedge and queues
//                the hand-derived expected outputs; a monitor on negedge pops
//                and compares every output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_sequencer;

    localparam int REG_W       = 4;
    localparam int TIMEOUT_CYC = 8;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    typedef struct {
        logic       frz;
        logic       bub;
        logic       fl;
        logic       fb;
        logic       req;
        logic       to;
        int         sc;
        int         fc;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             fwd_en;
    logic [REG_W-1:0] id_src1;
    logic [REG_W-1:0] id_src2;
    logic             id_two_src;
    logic [REG_W-1:0] exe_dest;
    logic             exe_wb_en;
    logic             exe_mem_rd;
    logic [REG_W-1:0] mem_dest;
    logic             mem_wb_en;
    logic             mem_rd_en;
    logic             mem_wr_en;
    logic             mem_ready;
    logic             branch_taken;
    logic             freeze_if_id;
    logic             bubble_exe;
    logic             flush_if_id;
    logic             flush_id_exe;
    logic             freeze_back;
    logic             mem_req;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   m_stall  = 0;
    int   m_flush  = 0;
    logic m_to     = 1'b0;

    pipeline_sequencer #(
        .REG_W       (REG_W),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fwd_en       (fwd_en),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_two_src   (id_two_src),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_rd   (exe_mem_rd),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .mem_rd_en    (mem_rd_en),
        .mem_wr_en    (mem_wr_en),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .freeze_if_id (freeze_if_id),
        .bubble_exe   (bubble_exe),
        .flush_if_id  (flush_if_id),
        .flush_id_exe (flush_id_exe),
        .freeze_back  (freeze_back),
        .mem_req      (mem_req),
        .mem_timeout  (mem_timeout),
        .stall_count  (stall_count),
        .flush_count  (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    // Monitor: compare every queued expectation at the negedge of its cycle.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("freeze_if_id", int'(freeze_if_id), int'(e.frz));
            chk("bubble_exe",   int'(bubble_exe),   int'(e.bub));
            chk("flush_if_id",  int'(flush_if_id),  int'(e.fl));
            chk("flush_id_exe", int'(flush_id_exe), int'(e.fl));
            chk("freeze_back",  int'(freeze_back),  int'(e.fb));
            chk("mem_req",      int'(mem_req),      int'(e.req));
            chk("mem_timeout",  int'(mem_timeout),  int'(e.to));
            chk("stall_count",  int'(stall_count),  e.sc);
            chk("flush_count",  int'(flush_count),  e.fc);
        end
    end

    task automatic clear();
        fwd_en       = 1'b0;
        id_src1      = '0;
        id_src2      = '0;
        id_two_src   = 1'b0;
        exe_dest     = '0;
        exe_wb_en    = 1'b0;
        exe_mem_rd   = 1'b0;
        mem_dest     = '0;
        mem_wb_en    = 1'b0;
        mem_rd_en    = 1'b0;
        mem_wr_en    = 1'b0;
        mem_ready    = 1'b0;
        branch_taken = 1'b0;
    endtask

    // One cycle: inputs already set; queue expected outputs, then advance.
    // ab marks the cycle on which an access is aborted by the watchdog.
    task automatic cyc(input logic frz, input logic bub, input logic fl,
                       input logic fb, input logic req, input logic ab);
        exp_t e;
        if (!rst_n) begin
            m_stall = 0;
            m_flush = 0;
            m_to    = 1'b0;
        end
        e.frz = frz; e.bub = bub; e.fl = fl; e.fb = fb; e.req = req;
        e.to  = m_to; e.sc = m_stall; e.fc = m_flush;
        sb.push_back(e);
        if (rst_n) begin
            if (frz && m_stall != CNT_MAX) m_stall++;
            if (fl && m_flush != CNT_MAX) m_flush++;
            if (ab) m_to = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        clear();
        repeat (2) @(posedge clk);
        #1;
        cyc(0,0,0,0,0,0);                       // reset state
        rst_n = 1'b1;
        cyc(0,0,0,0,0,0);

        // load-use hazard with forwarding on
        fwd_en = 1; exe_wb_en = 1; exe_mem_rd = 1; exe_dest = 3; id_src1 = 3;
        cyc(1,1,0,0,0,0);
        exe_mem_rd = 0;                          // ALU result forwards
        cyc(0,0,0,0,0,0);
        clear(); fwd_en = 1; mem_wb_en = 1; mem_dest = 3; id_src1 = 3;
        cyc(0,0,0,0,0,0);                        // MEM producer forwards

        // no-forward MEM hazard on second operand
        clear(); mem_wb_en = 1; mem_dest = 5; id_two_src = 1; id_src2 = 5;
        cyc(1,1,0,0,0,0);
        id_two_src = 0;
        cyc(0,0,0,0,0,0);
        clear(); exe_wb_en = 1; exe_dest = 7; id_src1 = 7;
        cyc(1,1,0,0,0,0);                        // no-forward EXE hazard
        exe_wb_en = 0;
        cyc(0,0,0,0,0,0);

        // branch flush beats a live hazard
        clear(); fwd_en = 1; exe_wb_en = 1; exe_mem_rd = 1; exe_dest = 3; id_src1 = 3;
        branch_taken = 1;
        cyc(0,0,1,0,0,0);
        clear();
        cyc(0,0,0,0,0,0);

        // zero-wait access
        mem_wr_en = 1; mem_ready = 1;
        cyc(0,0,0,0,1,0);
        clear();

        // SRAM wait, ready on 4th cycle
        mem_rd_en = 1;
        repeat (3) cyc(1,0,0,1,1,0);
        mem_ready = 1;
        cyc(0,0,0,0,1,0);
        clear();
        cyc(0,0,0,0,0,0);

        // branch and hazard under memory wait
        mem_rd_en = 1; branch_taken = 1;
        fwd_en = 1; exe_wb_en = 1; exe_mem_rd = 1; exe_dest = 3; id_src1 = 3;
        repeat (3) cyc(1,0,0,1,1,0);
        mem_ready = 1;
        cyc(0,0,1,0,1,0);
        clear();
        cyc(0,0,0,0,0,0);

        // reset mid-wait, then a late mem_ready with no access
        mem_rd_en = 1;
        repeat (2) cyc(1,0,0,1,1,0);
        rst_n = 0; clear();
        cyc(0,0,0,0,0,0);
        rst_n = 1; mem_ready = 1;
        cyc(0,0,0,0,0,0);
        clear();
        cyc(0,0,0,0,0,0);

        // timeout: abort on access cycle 8
        mem_wr_en = 1;
        repeat (TIMEOUT_CYC - 1) cyc(1,0,0,1,1,0);
        cyc(0,0,0,0,0,1);
        clear();
        repeat (2) cyc(0,0,0,0,0,0);             // mem_timeout sticky
        rst_n = 0;                               // asynchronous clear
        cyc(0,0,0,0,0,0);
        rst_n = 1;
        cyc(0,0,0,0,0,0);

        // counter saturation
        exe_wb_en = 1; exe_dest = 7; id_src1 = 7;
        repeat (CNT_MAX + 3) cyc(1,1,0,0,0,0);
        clear();
        cyc(0,0,0,0,0,0);
        branch_taken = 1;
        repeat (CNT_MAX + 2) cyc(0,0,1,0,0,0);
        clear();
        cyc(0,0,0,0,0,0);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pipeline_sequencer
`default_nettype wire
